// File: rtl/imem_loader.sv
// Boot loader for the CPU instruction memory: accepts a program as a
// valid/ready word stream, writes it through the external memory port,
// reads it back to check a wrapping 32-bit sum, then enables the CPU.
module imem_loader #(
  parameter int          ADDR_W    = 9,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              stop,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [31:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RUN, ERR} state_t;

  // Largest legal image: the whole memory (2**ADDR_W words).
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t          state_q, state_d;
  logic [ADDR_W:0] index_q, index_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [31:0]     sum_w_q, sum_w_d;
  logic [31:0]     sum_r_q, sum_r_d;
  logic            acc_q, acc_d;      // a read was issued last cycle
  logic [31:0]     addr_q, addr_d;    // last driven address, held when idle
  logic            done_q, done_d;
  logic            en_q, en_d;
  logic            err_q, err_d;

  logic            xfer;
  logic [31:0]     cur_addr;
  logic [31:0]     sum_r_fin;

  // Port drive: writes follow stream transfers combinationally, reads run
  // back-to-back through VERIFY until every word has been requested.
  always_comb begin
    xfer      = (state_q == LOAD) && s_valid;
    cur_addr  = BASE_ADDR + (32'(index_q) << 2);
    s_ready   = (state_q == LOAD);
    wen_ext   = xfer;
    ren_ext   = (state_q == VERIFY) && (index_q < len_q);
    addr_ext  = (wen_ext || ren_ext) ? cur_addr : addr_q;
    wdata_ext = wen_ext ? s_data : '0;
    busy      = (state_q == LOAD) || (state_q == VERIFY);
    done      = done_q;
    error     = err_q;
    cpu_enable = en_q;
    sum_r_fin = sum_r_q + 32'(rdata_ext);
  end

  // Next-state and datapath updates for the load/verify/run sequence.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    len_d   = len_q;
    sum_w_d = sum_w_q;
    sum_r_d = sum_r_q;
    acc_d   = ren_ext;
    addr_d  = addr_ext;
    done_d  = 1'b0;
    en_d    = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          if ((num_words == '0) || (num_words > MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            state_d = LOAD;
            len_d   = num_words;
            index_d = '0;
            sum_w_d = '0;
            sum_r_d = '0;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          sum_w_d = sum_w_q + 32'(s_data);
          if (index_q == len_q - 1'b1) begin
            index_d = '0;
            state_d = VERIFY;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      VERIFY: begin
        if (ren_ext) index_d = index_q + 1'b1;
        if (acc_q) sum_r_d = sum_r_fin;
        // Final cycle: no read left, last read data arriving now.
        if (acc_q && !ren_ext) begin
          if (sum_r_fin == sum_w_q) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
      end
      RUN: begin
        if (stop) state_d = IDLE;
        else      en_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    err_d = (state_d == ERR);
  end

  // State registers; async reset abandons any partial image.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      index_q <= '0;
      len_q   <= '0;
      sum_w_q <= '0;
      sum_r_q <= '0;
      acc_q   <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      len_q   <= len_d;
      sum_w_q <= sum_w_d;
      sum_r_q <= sum_r_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

endmodule
